scan_receiver: RTL and testbench

- Receiving end of the 16x16 nested h/k scan sequence: h is the inner (fast) coordinate, k the outer (slow) coordinate.
- Accepts data beats tagged with (h,k) and checks that they arrive in strict scan order: h increments first; when h wraps, k increments.
- Stores each in-order beat in a 2^DIM_BITS x 2^DIM_BITS frame buffer.
- Flags sequence errors, signals frame completion and exposes a registered random-access read port for downstream display/processing logic.

---
 rtl/scan_receiver.sv | 133 +++++++++++++
 tb/tb_scan_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_receiver.sv
// Receiver for the nested h/k scan: checks beats arrive in strict scan order,
// stores them in a frame buffer and exposes a registered random-access read port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a (0,0) beat to start a frame; other beats ignored
//   RECV  | frame in progress, expecting beat (exp_h, exp_k)
module scan_receiver #(
    parameter int DW       = 8,
    parameter int DIM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DIM_BITS-1:0] in_h,
    input  logic [DIM_BITS-1:0] in_k,
    input  logic [DW-1:0]       in_data,
    input  logic                rd_en,
    input  logic [DIM_BITS-1:0] rd_h,
    input  logic [DIM_BITS-1:0] rd_k,
    output logic [DW-1:0]       rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                frame_done,
    output logic                seq_err,
    output logic [7:0]          frame_cnt
);

    localparam int                  DEPTH = 1 << (2 * DIM_BITS);
    localparam logic [DIM_BITS-1:0] MAX   = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DIM_BITS-1:0] exp_h_q, exp_h_d;
    logic [DIM_BITS-1:0] exp_k_q, exp_k_d;
    logic                wr_en;
    logic                done_d;
    logic                err_d;
    logic                is_origin;
    logic                in_order;

    logic [DW-1:0] mem [0:DEPTH-1];

    assign is_origin = (in_h == '0) && (in_k == '0);
    assign in_order  = (in_h == exp_h_q) && (in_k == exp_k_q);

    always_comb begin
        state_d = state_q;
        exp_h_d = exp_h_q;
        exp_k_d = exp_k_q;
        wr_en   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && is_origin) begin
                    wr_en   = 1'b1;
                    exp_h_d = DIM_BITS'(1);
                    exp_k_d = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (in_valid) begin
                    if (in_order) begin
                        wr_en = 1'b1;
                        if (exp_h_q == MAX) begin
                            exp_h_d = '0;
                            exp_k_d = exp_k_q + 1'b1;
                        end else begin
                            exp_h_d = exp_h_q + 1'b1;
                        end
                        if (exp_h_q == MAX && exp_k_q == MAX) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        err_d = 1'b1;
                        // A stray (0,0) is taken as the start of a fresh frame.
                        if (is_origin) begin
                            wr_en   = 1'b1;
                            exp_h_d = DIM_BITS'(1);
                            exp_k_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            exp_h_q    <= '0;
            exp_k_q    <= '0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            frame_cnt  <= 8'd0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_h_q    <= exp_h_d;
            exp_k_q    <= exp_k_d;
            frame_done <= done_d;
            seq_err    <= err_d;
            if (done_d) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[{rd_k, rd_h}];
            end
        end
    end

    assign busy = (state_q == RECV);

    // Buffer is never reset; the read above sees the pre-write contents on a collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{in_k, in_h}] <= in_data;
        end
    end

endmodule

// File: tb/tb_scan_receiver.sv
// Directed bench for scan_receiver: full, gapped, error, restart, reset and wrap scenarios
// with hand-computed expected values.
module tb_scan_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_h = '0;
    logic [3:0] in_k = '0;
    logic [7:0] in_data = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_h = '0;
    logic [3:0] rd_k = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       frame_done;
    logic       seq_err;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    scan_receiver #(.DW(8), .DIM_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_h(in_h), .in_k(in_k), .in_data(in_data),
        .rd_en(rd_en), .rd_h(rd_h), .rd_k(rd_k),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .frame_done(frame_done), .seq_err(seq_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_done) done_cnt++;
        if (seq_err) err_cnt++;
    endtask

    task automatic beat(input logic [3:0] h, input logic [3:0] k, input logic [7:0] d);
        in_valid = 1'b1;
        in_h     = h;
        in_k     = k;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] h, input logic [3:0] k,
                           input logic [7:0] exp);
        rd_en = 1'b1;
        rd_h  = h;
        rd_k  = k;
        tick();
        rd_en = 1'b0;
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Beats start..255 in scan order, data = {k,h} ^ mask, 'gap' idle cycles between beats.
    task automatic send_frame(input int gap, input logic [7:0] mask, input int start,
                              input logic [7:0] exp_cnt);
        logic [7:0] idx;
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = start; i < 256; i++) begin
            idx = 8'(i);
            if (i != start) repeat (gap) tick();
            if (i == 255) chk("no_early_done", 32'(done_cnt), 32'd0);
            beat(idx[3:0], idx[7:4], idx ^ mask);
            if (i == 0) chk("busy_after_first", 32'(busy), 32'd1);
        end
        chk("frame_done_pulse", 32'(frame_done), 32'd1);
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("busy_after_last", 32'(busy), 32'd0);
        chk("no_seq_err_in_frame", 32'(err_cnt), 32'd0);
    endtask

    initial begin
        logic [7:0] idx;

        // Reset values, sampled while reset is held.
        #1;
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full frame back to back.
        send_frame(0, 8'h00, 0, 8'd1);
        tick();
        chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
        chk("single_done", 32'(done_cnt), 32'd1);
        do_read("read_35", 4'd5, 4'd3, 8'h35);
        tick();
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);
        chk("rd_data_hold", 32'(rd_data), 32'h35);

        // Gapped frame, 3 idle cycles between beats.
        send_frame(3, 8'h00, 0, 8'd2);
        tick();
        chk("gap_single_done", 32'(done_cnt), 32'd1);
        do_read("gap_read_a7", 4'd7, 4'd10, 8'hA7);

        // Skip error: (0,0)..(3,0) then (5,0).
        for (int h = 0; h < 4; h++) beat(4'(h), 4'd0, 8'hC0 | 8'(h));
        chk("skip_busy_before", 32'(busy), 32'd1);
        beat(4'd5, 4'd0, 8'hEE);
        chk("skip_seq_err", 32'(seq_err), 32'd1);
        chk("skip_busy", 32'(busy), 32'd0);
        chk("skip_frame_done", 32'(frame_done), 32'd0);
        tick();
        chk("skip_seq_err_clear", 32'(seq_err), 32'd0);
        do_read("skip_unchanged", 4'd5, 4'd0, 8'h05);
        do_read("skip_written", 4'd3, 4'd0, 8'hC3);
        beat(4'd7, 4'd2, 8'h99);
        chk("idle_ignore_err", 32'(seq_err), 32'd0);
        chk("idle_ignore_busy", 32'(busy), 32'd0);
        tick();
        chk("idle_ignore_err2", 32'(seq_err), 32'd0);
        do_read("idle_ignore_nowrite", 4'd7, 4'd2, 8'h27);

        // Restart: (0,0)..(9,4) then (0,0)=0xAA, then the remainder of the scan.
        do_reset();
        for (int i = 0; i <= 16 * 4 + 9; i++) begin
            idx = 8'(i);
            beat(idx[3:0], idx[7:4], idx ^ 8'h55);
        end
        beat(4'd0, 4'd0, 8'hAA);
        chk("restart_seq_err", 32'(seq_err), 32'd1);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_no_done", 32'(frame_done), 32'd0);
        do_read("restart_origin", 4'd0, 4'd0, 8'hAA);
        send_frame(0, 8'h00, 1, 8'd1);
        do_read("restart_origin_kept", 4'd0, 4'd0, 8'hAA);
        do_read("restart_rewrite", 4'd9, 4'd4, 8'h49);

        // Reset mid-frame with frame_cnt = 2.
        do_reset();
        send_frame(0, 8'h00, 0, 8'd1);
        send_frame(0, 8'h00, 0, 8'd2);
        for (int i = 0; i < 100; i++) begin
            idx = 8'(i);
            beat(idx[3:0], idx[7:4], idx);
        end
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        chk("mid_rst_seq_err", 32'(seq_err), 32'd0);
        tick();
        rst_n = 1'b1;
        send_frame(0, 8'h00, 0, 8'd1);

        // 256 frames, data = {k,h} ^ frame index; collide a read in the last frame.
        do_reset();
        for (int f = 0; f < 255; f++) send_frame(0, 8'(f), 0, 8'(f + 1));
        chk("wrap_pre_cnt", 32'(frame_cnt), 32'd255);
        for (int i = 0; i < 256; i++) begin
            idx = 8'(i);
            if (i == 16 * 3 + 5) begin
                rd_en = 1'b1;
                rd_h  = 4'd5;
                rd_k  = 4'd3;
            end
            beat(idx[3:0], idx[7:4], idx ^ 8'hFF);
            if (i == 16 * 3 + 5) begin
                rd_en = 1'b0;
                chk("collide_rd_valid", 32'(rd_valid), 32'd1);
                chk("collide_old_data", 32'(rd_data), 32'(8'h35 ^ 8'hFE));
            end
        end
        chk("wrap_done", 32'(frame_done), 32'd1);
        chk("wrap_cnt_zero", 32'(frame_cnt), 32'd0);
        do_read("collide_new_data", 4'd5, 4'd3, 8'h35 ^ 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
